// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register file's single write port between NREQ writeback
//   requesters (ALU, load, mul/div). A round-robin arbiter picks one
//   requester per cycle. A registered stage drives the regfile write port.
//   A busy-bit scoreboard flags RAW hazards on decode source operands and
//   WAW stalls on issue.
//
//   Optional feature macro: WB_ARB_BYPASS_EN
//     When defined, a source operand that is being written back this cycle is
//     not reported as a hazard, because the regfile forwards rf_in to it.
//
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   req_valid/rd/data      per-requester writeback (flattened, requester 0 at LSB)
//   req_ready              one-hot grant (combinational, never back-pressured)
//   issue_valid/rd         decode issues an instruction writing issue_rd
//   issue_stall            issue_rd already has an outstanding producer (WAW)
//   chk_rs1/2, hazard_rs1/2  RAW hazard query for decode source operands
//   rf_en/rd/in            register file write port
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_stall,
  input  logic [AW-1:0]        chk_rs1,
  input  logic [AW-1:0]        chk_rs2,
  output logic                 hazard_rs1,
  output logic                 hazard_rs2,
  output logic                 rf_en,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_in
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  // (base + k) mod NREQ, with base < NREQ and k <= NREQ
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  logic            gnt_any;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            wb_vld_p0;

  logic            vld_p1;
  logic [AW-1:0]   rf_rd_p1;
  logic [XLEN-1:0] rf_in_p1;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            issue_set;

  // ---- stage p0: round-robin arbitration --------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_inc(rr_ptr, k);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // no handshake may complete while reset is held
    if (reset) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_rd    = req_rd[int'(gnt_idx)*AW +: AW];
  assign gnt_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];
  // writes to x0 are accepted but never reach the regfile
  assign wb_vld_p0 = gnt_any && (gnt_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= wrap_inc(gnt_idx, 1);
  end

  // ---- stage p1: registered regfile write port ---------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rf_rd_p1 <= '0;
      rf_in_p1 <= '0;
    end else begin
      vld_p1 <= wb_vld_p0;
      if (wb_vld_p0) begin
        rf_rd_p1 <= gnt_rd;
        rf_in_p1 <= gnt_data;
      end
    end
  end

  assign rf_en = vld_p1;
  assign rf_rd = rf_rd_p1;
  assign rf_in = rf_in_p1;

  // ---- scoreboard --------------------------------------------------------
  assign issue_stall = issue_valid && busy[issue_rd];
  assign issue_set   = issue_valid && !issue_stall && (issue_rd != '0);

  // set is applied after clear so a newer producer keeps the bit
  always_comb begin
    busy_nxt = busy;
    if (vld_p1)    busy_nxt[rf_rd_p1] = 1'b0;
    if (issue_set) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

`ifdef WB_ARB_BYPASS_EN
  assign hazard_rs1 = busy[chk_rs1] && !(vld_p1 && (rf_rd_p1 == chk_rs1));
  assign hazard_rs2 = busy[chk_rs2] && !(vld_p1 && (rf_rd_p1 == chk_rs2));
`else
  assign hazard_rs1 = busy[chk_rs1];
  assign hazard_rs2 = busy[chk_rs2];
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;
`ifdef WB_ARB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 issue_stall;
  logic [AW-1:0]        chk_rs1;
  logic [AW-1:0]        chk_rs2;
  logic                 hazard_rs1;
  logic                 hazard_rs2;
  logic                 rf_en;
  logic [AW-1:0]        rf_rd;
  logic [XLEN-1:0]      rf_in;

  wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_in(rf_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // monitor: every regfile write must match the oldest expected writeback
  always @(negedge clk) begin
    if (!reset && rf_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write (t=%0t)", rf_rd, rf_in, $time);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(rf_rd), 64'(e.rd));
        chk("wb_data", rf_in, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    chk_rs1     = '0;
    chk_rs2     = '0;
    #2 reset = 1'b1;
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};

    // reset state with all requesters valid
    @(negedge clk);
    chk("rst_rf_en", 64'(rf_en), 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_in", rf_in, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    next_cycle();
    reset = 1'b0;

    // fairness: all valid for 6 cycles -> grants 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      req_data = {64'(k*16+2), 64'(k*16+1), 64'(k*16)};
      exp_q.push_back('{rd: 5'(k%3+1), data: 64'(k*16 + k%3)});
      @(negedge clk);
      chk("fair_ready", 64'(req_ready), 64'(1 << (k%3)));
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    next_cycle();

    // reset mid-operation: staged write and busy bits discarded
    req_valid   = 3'b111;
    req_data    = {64'hB2, 64'hB1, 64'hB0};
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    exp_q.push_back('{rd: 5'd1, data: 64'hB0});
    @(negedge clk);
    chk("pre_rst_ready", 64'(req_ready), 64'b001);
    next_cycle();
    issue_valid = 1'b0;
    chk_rs1     = 5'd4;
    #1;
    chk("pre_rst_hazard", 64'(hazard_rs1), 64'd1);
    chk("pre_rst_rf_en", 64'(rf_en), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_rf_en", 64'(rf_en), 64'd0);
    chk("midrst_rf_rd", 64'(rf_rd), 64'd0);
    chk("midrst_rf_in", rf_in, 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    chk("midrst_busy", 64'(hazard_rs1), 64'd0);
    next_cycle();
    reset = 1'b0;
    exp_q.push_back('{rd: 5'd1, data: 64'hB0});
    @(negedge clk);
    chk("post_rst_first", 64'(req_ready), 64'b001);
    next_cycle();

    // scoreboard: issue rd5, then req1 writes rd5
    req_valid   = '0;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    chk_rs1     = 5'd5;
    @(negedge clk);
    chk("sb_issue_stall", 64'(issue_stall), 64'd0);
    chk("sb_hazard_pre", 64'(hazard_rs1), 64'd0);
    next_cycle();
    issue_valid = 1'b0;
    req_valid   = 3'b010;
    req_rd      = {5'd0, 5'd5, 5'd0};
    req_data    = {64'h0, 64'hDEAD, 64'h0};
    exp_q.push_back('{rd: 5'd5, data: 64'hDEAD});
    @(negedge clk);
    chk("sb_hazard_busy", 64'(hazard_rs1), 64'd1);
    chk("sb_ready", 64'(req_ready), 64'b010);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("sb_hazard_wb", 64'(hazard_rs1), BYP ? 64'd0 : 64'd1);
    next_cycle();
    @(negedge clk);
    chk("sb_hazard_clr", 64'(hazard_rs1), 64'd0);
    next_cycle();

    // same-cycle set/clear on rd7: set wins
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd7};
    req_data  = {64'h0, 64'h0, 64'h77};
    exp_q.push_back('{rd: 5'd7, data: 64'h77});
    @(negedge clk);
    chk("sc_ready", 64'(req_ready), 64'b001);
    next_cycle();
    req_valid   = '0;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    chk_rs1     = 5'd7;
    @(negedge clk);
    chk("sc_stall_first", 64'(issue_stall), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("sc_stall_second", 64'(issue_stall), 64'd1);
    chk("sc_hazard", 64'(hazard_rs1), 64'd1);
    next_cycle();

    // x0: accepted, never written, never busy
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    chk_rs1     = 5'd0;
    req_valid   = 3'b100;
    req_rd      = '0;
    req_data    = {64'h55, 64'h0, 64'h0};
    @(negedge clk);
    chk("x0_ready", 64'(req_ready), 64'b100);
    chk("x0_stall", 64'(issue_stall), 64'd0);
    next_cycle();
    issue_valid = 1'b0;
    req_valid   = '0;
    @(negedge clk);
    chk("x0_rf_en", 64'(rf_en), 64'd0);
    chk("x0_hazard", 64'(hazard_rs1), 64'd0);
    next_cycle();

    // bypass on rs2 during the write cycle
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    chk_rs2     = 5'd9;
    @(negedge clk);
    chk("byp_hazard_pre", 64'(hazard_rs2), 64'd0);
    next_cycle();
    issue_valid = 1'b0;
    req_valid   = 3'b010;
    req_rd      = {5'd0, 5'd9, 5'd0};
    req_data    = {64'h0, 64'h99, 64'h0};
    exp_q.push_back('{rd: 5'd9, data: 64'h99});
    @(negedge clk);
    chk("byp_ready", 64'(req_ready), 64'b010);
    chk("byp_hazard_busy", 64'(hazard_rs2), 64'd1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("byp_rf_en", 64'(rf_en), 64'd1);
    chk("byp_hazard_wb", 64'(hazard_rs2), BYP ? 64'd0 : 64'd1);
    next_cycle();
    @(negedge clk);
    chk("byp_hazard_clr", 64'(hazard_rs2), 64'd0);
    next_cycle();
    @(negedge clk);
    next_cycle();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
